pump_rotation_controller: RTL and testbench
===========================================

PUMP_ROTATION_CONTROLLER -- requirements
Module: pump_rotation_controller

Interface
REQ-001 Parameter DEBOUNCE, default 3: consecutive identical sensor samples required before the filtered level changes (range 1..255).
REQ-002 Parameter MIN_ON, default 8: minimum cycles a pumping cycle lasts from IDLE exit (range 1..255).
REQ-003 Parameter LAG_DELAY, default 4: consecutive cycles of filtered 11 in LEAD_ON before the lag pump starts (range 1..255).
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sensors  input  2  bit0 = level above low mark (I), bit1 = level above high mark (S); 2'b10 is physically impossible.
REQ-007 pumps  output  2  pump run commands; bit n drives pump n.
REQ-008 lead  output  1  index of the current lead pump.
REQ-009 fault  output  1  sticky fault indicator.
REQ-010 current_state  output  2  state register value.

Function
REQ-011 The block SHALL filter sensors: filt takes value v on the edge completing DEBOUNCE consecutive sampled edges with sensors == v != filt; any differing sample restarts the count.
REQ-012 States SHALL be IDLE=00, LEAD_ON=01, BOTH_ON=10, FAULT=11, registered; outputs are decoded from the state register, so pumps respond one edge after filt changes.
REQ-013 pumps SHALL be 00 in IDLE and FAULT, one-hot at bit lead in LEAD_ON, and 11 in BOTH_ON.
REQ-014 IDLE -> LEAD_ON when filt == 11; on_timer clears to 0 on this transition.
REQ-015 In LEAD_ON and BOTH_ON, on_timer SHALL increment every cycle, saturating at MIN_ON.
REQ-016 In LEAD_ON, lag_timer SHALL count consecutive cycles with filt == 11 and clear otherwise; LEAD_ON -> BOTH_ON when lag_timer reaches LAG_DELAY; the timer saturates and does not wrap.
REQ-017 BOTH_ON -> LEAD_ON when filt == 01; lag_timer SHALL clear on entry to LEAD_ON.
REQ-018 LEAD_ON or BOTH_ON with filt == 00: go to IDLE if on_timer == MIN_ON; otherwise BOTH_ON goes to LEAD_ON and LEAD_ON holds.
REQ-019 On every transition into IDLE from LEAD_ON or BOTH_ON, lead SHALL toggle on the same edge.
REQ-020 From any non-FAULT state, filt == 10 SHALL transition to FAULT, taking priority over all other transitions.
REQ-021 FAULT SHALL be exited only by reset; fault = 1 exactly while in FAULT.
REQ-022 A raw 10 glitch shorter than DEBOUNCE cycles SHALL have no effect.

Reset
REQ-023 While reset is high at an edge: state = IDLE, filt = 00, lead = 0, all counters = 0, pumps = 00, fault = 0.
REQ-024 Reset asserted mid-operation (any state) SHALL take effect on the next edge, with no pump left running.
REQ-025 Reset SHALL take priority over all sensor-driven transitions on the same edge.

Structure
REQ-026 A shared package pump_ctrl_pkg SHALL hold the state encodings, the sensor bit indices (SENSOR_LOW=0, SENSOR_HIGH=1) and the parameter defaults.
REQ-027 Debounce SHALL be a sub-module, sensor_debounce (2-bit, parameter DEBOUNCE), instantiated once.
REQ-028 Counters SHALL be 8 bits wide.

Verification (defaults; edge 1 is the first edge after reset deasserts)
REQ-029 Hold sensors = 11 from edge 1: filt = 11 after edge 3, state LEAD_ON and pumps = 01 after edge 4, BOTH_ON and pumps = 11 after edge 8.
REQ-030 From BOTH_ON, sensors = 01 for 3 edges: state LEAD_ON, pumps = 01; then sensors = 00 with on_timer saturated: IDLE, pumps = 00, lead = 1; the next fill yields pumps = 10.
REQ-031 Enter LEAD_ON, then apply sensors = 00 immediately: pumps stay 01 until on_timer = 8, then IDLE is reached exactly one edge later.
REQ-032 sensors = 10 for 2 cycles in LEAD_ON: no change; sensors = 10 for 3 cycles: FAULT, pumps = 00, fault = 1; later sensors = 00 or 11 leave it in FAULT; reset returns it to IDLE with fault = 0.
REQ-033 Reset pulse in BOTH_ON: the next edge gives IDLE, pumps = 00, lead = 0, current_state = 00.
REQ-034 Alternating sensors 11/01 every cycle: filt stays at its previous value and the state does not change.

Source files
------------

// File: rtl/pump_ctrl_pkg.sv
// Shared definitions for the duplex pump rotation controller: state encoding,
// sensor bit positions, level patterns, parameter defaults and counter helpers.
package pump_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_LEAD_ON = 2'b01,
        ST_BOTH_ON = 2'b10,
        ST_FAULT   = 2'b11
    } pump_state_e;

    localparam int unsigned SENSOR_LOW  = 0;
    localparam int unsigned SENSOR_HIGH = 1;

    localparam int unsigned DEBOUNCE_DEFAULT  = 3;
    localparam int unsigned MIN_ON_DEFAULT    = 8;
    localparam int unsigned LAG_DELAY_DEFAULT = 4;

    localparam logic [1:0] LEVEL_EMPTY = 2'b00;
    localparam logic [1:0] LEVEL_LOW   = 2'b01;
    localparam logic [1:0] LEVEL_FULL  = 2'b11;

    // High mark wet while low mark dry cannot happen with a healthy sensor pair.
    function automatic logic level_is_bad(input logic [1:0] lvl);
        return lvl[SENSOR_HIGH] & ~lvl[SENSOR_LOW];
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] value, input logic [7:0] limit);
        logic [7:0] result;
        if (value >= limit) begin
            result = limit;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-bit level filter: the output follows the input only after DEBOUNCE
// consecutive identical samples that differ from the current filtered value.
module sensor_debounce
    import pump_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] din,
    output logic [1:0] filt
);

    localparam logic [7:0] DEB_C = 8'(DEBOUNCE);

    logic [1:0] filt_q, filt_d;
    logic [1:0] cand_q, cand_d;
    logic [7:0] cnt_q,  cnt_d;
    logic [7:0] run_s;

    // Candidate tracking and filtered-level update.
    always_comb begin
        filt_d = filt_q;
        cand_d = cand_q;
        cnt_d  = cnt_q;
        // A zero count means no run is in progress, whatever cand_q holds.
        if ((din == cand_q) && (cnt_q != 8'd0)) begin
            run_s = cnt_q + 8'd1;
        end else begin
            run_s = 8'd1;
        end
        if (din == filt_q) begin
            cnt_d = 8'd0;
        end else if (run_s >= DEB_C) begin
            filt_d = din;
            cnt_d  = 8'd0;
        end else begin
            cand_d = din;
            cnt_d  = run_s;
        end
    end

    // Filter state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            filt_q <= 2'b00;
            cand_q <= 2'b00;
            cnt_q  <= 8'd0;
        end else begin
            filt_q <= filt_d;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/pump_rotation_controller.sv
// Duplex sump pump controller: lead pump on a full tank, lag pump added when the
// tank stays full, minimum run time, lead rotation per cycle and a sticky fault.
module pump_rotation_controller
    import pump_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE  = DEBOUNCE_DEFAULT,
    parameter int unsigned MIN_ON    = MIN_ON_DEFAULT,
    parameter int unsigned LAG_DELAY = LAG_DELAY_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] sensors,
    output logic [1:0] pumps,
    output logic       lead,
    output logic       fault,
    output logic [1:0] current_state
);

    localparam logic [7:0] MIN_ON_C    = 8'(MIN_ON);
    localparam logic [7:0] LAG_DELAY_C = 8'(LAG_DELAY);

    logic [1:0]  filt_s;
    pump_state_e state_q, state_d;
    logic [7:0]  on_q, on_d;
    logic [7:0]  lag_q, lag_d;
    logic        lead_q, lead_d;
    logic [1:0]  pumps_q, pumps_d;
    logic        fault_q, fault_d;
    logic [7:0]  on_inc_s;
    logic [7:0]  lag_inc_s;

    sensor_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clock (clock),
        .reset (reset),
        .din   (sensors),
        .filt  (filt_s)
    );

    // Next-state, timer and lead-rotation logic.
    always_comb begin
        state_d   = state_q;
        on_d      = on_q;
        lag_d     = lag_q;
        lead_d    = lead_q;
        on_inc_s  = sat_inc(on_q, MIN_ON_C);
        lag_inc_s = sat_inc(lag_q, LAG_DELAY_C);
        case (state_q)
            ST_IDLE: begin
                on_d  = 8'd0;
                lag_d = 8'd0;
                if (level_is_bad(filt_s)) begin
                    state_d = ST_FAULT;
                end else if (filt_s == LEVEL_FULL) begin
                    state_d = ST_LEAD_ON;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LEAD_ON: begin
                on_d = on_inc_s;
                if (level_is_bad(filt_s)) begin
                    state_d = ST_FAULT;
                end else if (filt_s == LEVEL_FULL) begin
                    lag_d = lag_inc_s;
                    if (lag_inc_s >= LAG_DELAY_C) begin
                        state_d = ST_BOTH_ON;
                    end else begin
                        state_d = ST_LEAD_ON;
                    end
                end else if ((filt_s == LEVEL_EMPTY) && (on_q == MIN_ON_C)) begin
                    lag_d   = 8'd0;
                    state_d = ST_IDLE;
                    lead_d  = ~lead_q;
                end else begin
                    lag_d   = 8'd0;
                    state_d = ST_LEAD_ON;
                end
            end
            ST_BOTH_ON: begin
                on_d = on_inc_s;
                if (level_is_bad(filt_s)) begin
                    state_d = ST_FAULT;
                end else if (filt_s == LEVEL_LOW) begin
                    lag_d   = 8'd0;
                    state_d = ST_LEAD_ON;
                end else if (filt_s == LEVEL_EMPTY) begin
                    lag_d = 8'd0;
                    // Minimum run not yet met: shed the lag pump but keep pumping.
                    if (on_q == MIN_ON_C) begin
                        state_d = ST_IDLE;
                        lead_d  = ~lead_q;
                    end else begin
                        state_d = ST_LEAD_ON;
                    end
                end else begin
                    state_d = ST_BOTH_ON;
                end
            end
            ST_FAULT: begin
                on_d    = 8'd0;
                lag_d   = 8'd0;
                state_d = ST_FAULT;
            end
            default: begin
                on_d    = 8'd0;
                lag_d   = 8'd0;
                state_d = ST_FAULT;
            end
        endcase
    end

    // Output decode from the next state so outputs register alongside it.
    always_comb begin
        pumps_d = 2'b00;
        fault_d = 1'b0;
        case (state_d)
            ST_IDLE: begin
                pumps_d = 2'b00;
            end
            ST_LEAD_ON: begin
                if (lead_d) begin
                    pumps_d = 2'b10;
                end else begin
                    pumps_d = 2'b01;
                end
            end
            ST_BOTH_ON: begin
                pumps_d = 2'b11;
            end
            ST_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                pumps_d = 2'b00;
                fault_d = 1'b1;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            on_q    <= 8'd0;
            lag_q   <= 8'd0;
            lead_q  <= 1'b0;
            pumps_q <= 2'b00;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            on_q    <= on_d;
            lag_q   <= lag_d;
            lead_q  <= lead_d;
            pumps_q <= pumps_d;
            fault_q <= fault_d;
        end
    end

    assign pumps         = pumps_q;
    assign lead          = lead_q;
    assign fault         = fault_q;
    assign current_state = state_q;

endmodule

// File: tb/tb_pump_rotation_controller.sv
// Randomised and directed bench for pump_rotation_controller against a
// behavioural model built from the level-control rules.
module tb_pump_rotation_controller;

    localparam int DEB = 3;
    localparam int MINON = 8;
    localparam int LAGD = 4;
    localparam int S_IDLE = 0;
    localparam int S_LEAD = 1;
    localparam int S_BOTH = 2;
    localparam int S_FAULT = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] sensors;
    logic [1:0] pumps;
    logic       lead;
    logic       fault;
    logic [1:0] current_state;

    int vectors = 0;
    int miscompares = 0;
    logic [5:0] obs;

    int         m_state;
    int         m_on;
    int         m_lag;
    bit         m_lead;
    logic [1:0] m_filt;
    logic [1:0] hist[$];

    pump_rotation_controller #(
        .DEBOUNCE  (DEB),
        .MIN_ON    (MINON),
        .LAG_DELAY (LAGD)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .sensors       (sensors),
        .pumps         (pumps),
        .lead          (lead),
        .fault         (fault),
        .current_state (current_state)
    );

    always #5 clock = ~clock;

    function automatic logic [5:0] model_out();
        logic [1:0] p;
        case (m_state)
            S_LEAD:  p = m_lead ? 2'b10 : 2'b01;
            S_BOTH:  p = 2'b11;
            default: p = 2'b00;
        endcase
        return {2'(m_state), p, m_lead, (m_state == S_FAULT)};
    endfunction

    // One clock edge of the reference model: level rules first, then filtering.
    task automatic model_edge(input logic [1:0] s, input bit r);
        int  prev_on;
        bit  same;
        if (r) begin
            m_state = S_IDLE; m_on = 0; m_lag = 0; m_lead = 0; m_filt = 2'b00;
            hist.delete();
        end else begin
            prev_on = m_on;
            case (m_state)
                S_IDLE: begin
                    if (m_filt == 2'b10) m_state = S_FAULT;
                    else if (m_filt == 2'b11) begin m_state = S_LEAD; m_on = 0; m_lag = 0; end
                end
                S_LEAD: begin
                    m_on = (m_on + 1 > MINON) ? MINON : m_on + 1;
                    if (m_filt == 2'b10) m_state = S_FAULT;
                    else if (m_filt == 2'b11) begin
                        m_lag = (m_lag + 1 > LAGD) ? LAGD : m_lag + 1;
                        if (m_lag == LAGD) m_state = S_BOTH;
                    end else begin
                        m_lag = 0;
                        if (m_filt == 2'b00 && prev_on == MINON) begin
                            m_state = S_IDLE; m_lead = !m_lead;
                        end
                    end
                end
                S_BOTH: begin
                    m_on = (m_on + 1 > MINON) ? MINON : m_on + 1;
                    if (m_filt == 2'b10) m_state = S_FAULT;
                    else if (m_filt == 2'b01) begin m_state = S_LEAD; m_lag = 0; end
                    else if (m_filt == 2'b00) begin
                        m_lag = 0;
                        if (prev_on == MINON) begin m_state = S_IDLE; m_lead = !m_lead; end
                        else m_state = S_LEAD;
                    end
                end
                default: m_state = S_FAULT;
            endcase
            hist.push_back(s);
            if (hist.size() > DEB) void'(hist.pop_front());
            same = (hist.size() == DEB);
            foreach (hist[i]) if (hist[i] != s) same = 0;
            if (same && s != m_filt) m_filt = s;
        end
    endtask

    task automatic step(input logic [1:0] s, input bit r);
        sensors = s;
        reset = r;
        @(posedge clock);
        model_edge(s, r);
        #1;
    endtask

    task automatic test_reset();
        step(2'b11, 1'b1);
        step(2'b11, 1'b1);
        obs = {current_state, pumps, lead, fault};
        vectors++;
        if (obs !== 6'b000000) begin
            miscompares++;
            $display("FAIL reset_state: got %b, expected %b", obs, 6'b000000);
        end
    endtask

    task automatic test_fill();
        logic [3:0] exp_tab [1:8];
        exp_tab[1] = 4'b0000; exp_tab[2] = 4'b0000; exp_tab[3] = 4'b0000;
        exp_tab[4] = 4'b0101; exp_tab[5] = 4'b0101; exp_tab[6] = 4'b0101;
        exp_tab[7] = 4'b0101; exp_tab[8] = 4'b1011;
        step(2'b11, 1'b1);
        for (int e = 1; e <= 8; e++) begin
            step(2'b11, 1'b0);
            vectors++;
            if ({current_state, pumps} !== exp_tab[e]) begin
                miscompares++;
                $display("FAIL fill edge %0d: got state/pumps %b, expected %b", e, {current_state, pumps}, exp_tab[e]);
            end
        end
    endtask

    task automatic test_rotation();
        for (int e = 1; e <= 4; e++) step(2'b01, 1'b0);
        obs = {current_state, pumps, lead, fault};
        vectors++;
        if (obs !== 6'b010100 || obs !== model_out()) begin
            miscompares++;
            $display("FAIL rotation_shed_lag: got %b, expected %b", obs, 6'b010100);
        end
        for (int e = 1; e <= 4; e++) step(2'b00, 1'b0);
        obs = {current_state, pumps, lead, fault};
        vectors++;
        if (obs !== 6'b000010 || obs !== model_out()) begin
            miscompares++;
            $display("FAIL rotation_idle: got %b, expected %b", obs, 6'b000010);
        end
        for (int e = 1; e <= 4; e++) step(2'b11, 1'b0);
        obs = {current_state, pumps, lead, fault};
        vectors++;
        if (obs !== 6'b011010 || obs !== model_out()) begin
            miscompares++;
            $display("FAIL rotation_new_lead: got %b, expected %b", obs, 6'b011010);
        end
    endtask

    task automatic test_min_on();
        int n;
        step(2'b00, 1'b1);
        for (int e = 1; e <= 4; e++) step(2'b11, 1'b0);
        n = 0;
        while (current_state != 2'b00 && n < 40) begin
            step(2'b00, 1'b0);
            n++;
            obs = {current_state, pumps, lead, fault};
            vectors++;
            if (obs !== model_out()) begin
                miscompares++;
                $display("FAIL min_on step %0d: got %b, expected %b", n, obs, model_out());
            end
        end
        vectors++;
        if (n != 9) begin
            miscompares++;
            $display("FAIL min_on_latency: got %0d edges, expected 9", n);
        end
    endtask

    task automatic test_fault();
        step(2'b00, 1'b1);
        for (int e = 1; e <= 4; e++) step(2'b11, 1'b0);
        step(2'b10, 1'b0);
        step(2'b10, 1'b0);
        for (int e = 1; e <= 3; e++) step(2'b11, 1'b0);
        obs = {current_state, pumps, lead, fault};
        vectors++;
        if (fault !== 1'b0 || obs !== model_out()) begin
            miscompares++;
            $display("FAIL fault_glitch: got %b, expected %b", obs, model_out());
        end
        for (int e = 1; e <= 4; e++) step(2'b10, 1'b0);
        obs = {current_state, pumps, lead, fault};
        vectors++;
        if (obs !== 6'b110001 || obs !== model_out()) begin
            miscompares++;
            $display("FAIL fault_entry: got %b, expected %b", obs, 6'b110001);
        end
        for (int e = 1; e <= 6; e++) step(2'b00, 1'b0);
        for (int e = 1; e <= 6; e++) step(2'b11, 1'b0);
        obs = {current_state, pumps, lead, fault};
        vectors++;
        if (obs !== 6'b110001) begin
            miscompares++;
            $display("FAIL fault_sticky: got %b, expected %b", obs, 6'b110001);
        end
        step(2'b11, 1'b1);
        obs = {current_state, pumps, lead, fault};
        vectors++;
        if (obs !== 6'b000000) begin
            miscompares++;
            $display("FAIL fault_reset: got %b, expected %b", obs, 6'b000000);
        end
    endtask

    task automatic test_reset_mid();
        step(2'b00, 1'b1);
        for (int e = 1; e <= 8; e++) step(2'b11, 1'b0);
        for (int e = 1; e <= 4; e++) step(2'b00, 1'b0);
        for (int e = 1; e <= 8; e++) step(2'b11, 1'b0);
        obs = {current_state, pumps, lead, fault};
        vectors++;
        if (obs !== 6'b101110 || obs !== model_out()) begin
            miscompares++;
            $display("FAIL reset_mid_setup: got %b, expected %b", obs, 6'b101110);
        end
        step(2'b11, 1'b1);
        obs = {current_state, pumps, lead, fault};
        vectors++;
        if (obs !== 6'b000000) begin
            miscompares++;
            $display("FAIL reset_mid: got %b, expected %b", obs, 6'b000000);
        end
    endtask

    task automatic test_alternate();
        step(2'b00, 1'b1);
        for (int e = 0; e < 20; e++) begin
            step((e % 2 == 0) ? 2'b11 : 2'b01, 1'b0);
            vectors++;
            if (current_state !== 2'b00) begin
                miscompares++;
                $display("FAIL alternate_idle %0d: got state %b, expected 00", e, current_state);
            end
        end
        for (int e = 1; e <= 8; e++) step(2'b11, 1'b0);
        for (int e = 0; e < 20; e++) begin
            step((e % 2 == 0) ? 2'b01 : 2'b11, 1'b0);
            vectors++;
            if (current_state !== 2'b10 || pumps !== 2'b11) begin
                miscompares++;
                $display("FAIL alternate_both %0d: got state %b pumps %b, expected 10 11", e, current_state, pumps);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] s;
        int pick;
        int len;
        step(2'b00, 1'b1);
        for (int run = 0; run < 400; run++) begin
            pick = $urandom_range(0, 99);
            if (pick < 3) s = 2'b10;
            else if (pick < 35) s = 2'b00;
            else if (pick < 60) s = 2'b01;
            else s = 2'b11;
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) begin
                step(s, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
                obs = {current_state, pumps, lead, fault};
                vectors++;
                if (obs !== model_out()) begin
                    miscompares++;
                    $display("FAIL random run %0d: got %b, expected %b", run, obs, model_out());
                end
            end
        end
    endtask

    initial begin
        sensors = 2'b00;
        reset = 1'b1;
        m_state = S_IDLE; m_on = 0; m_lag = 0; m_lead = 0; m_filt = 2'b00;
        test_reset();
        test_fill();
        test_rotation();
        test_min_on();
        test_fault();
        test_reset_mid();
        test_alternate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
